// File: rtl/multicycle_ctrl_if.sv
// Control-sequencer bus: datapath status into the controller, select/enable
// lines and status out of it.
//   master : the controller (drives controls, state, err, instr_count)
//   slave  : the datapath/memory side (drives opcode, zero, mem_ready)
interface multicycle_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic [6:0]       opcode;
  logic             zero;
  logic             mem_ready;
  logic [2:0]       state;
  logic             mem_req;
  logic             mem_we;
  logic             i_or_d;
  logic             ir_write;
  logic             pc_write;
  logic             pc_src;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic             reg_write;
  logic             mem_to_reg;
  logic [1:0]       err;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  opcode, zero, mem_ready,
    output state, mem_req, mem_we, i_or_d, ir_write, pc_write, pc_src,
           alu_src_a, alu_src_b, alu_op, reg_write, mem_to_reg, err, instr_count
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  state, mem_req, mem_we, i_or_d, ir_write, pc_write, pc_src,
           alu_src_a, alu_src_b, alu_op, reg_write, mem_to_reg, err, instr_count
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/WB over a shared
// memory port, with a memory-response timeout and a sticky ERROR state.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-low reset
//   bus   - multicycle_ctrl_if.master (opcode/zero/mem_ready in; datapath
//           selects/enables, state, err, instr_count out)
module multicycle_ctrl #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic               clk,
  input  logic               reset,
  multicycle_ctrl_if.master  bus
);

  localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_ERROR  = 3'd7
  } state_e;

  state_e            r_state;
  logic [1:0]        r_err;
  logic [CNT_W-1:0]  r_instr_count;
  logic [WAIT_W-1:0] r_wait;

  logic w_is_r, w_is_i, w_is_ld, w_is_sd, w_is_beq, w_legal;
  logic w_timeout;

  // Opcode class decode
  assign w_is_r   = (bus.opcode == OP_R);
  assign w_is_i   = (bus.opcode == OP_I);
  assign w_is_ld  = (bus.opcode == OP_LD);
  assign w_is_sd  = (bus.opcode == OP_SD);
  assign w_is_beq = (bus.opcode == OP_BEQ);
  assign w_legal  = w_is_r | w_is_i | w_is_ld | w_is_sd | w_is_beq;

  // Last allowed request cycle still unanswered; mem_ready wins over it
  assign w_timeout = !bus.mem_ready && (r_wait == WAIT_W'(TIMEOUT - 1));

  // Sequencer: state, error cause, wait counter, retired-instruction count.
  // The wait counter is zero whenever a request phase is entered because it
  // only survives a cycle while a request stays unanswered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_err         <= 2'b00;
      r_instr_count <= '0;
      r_wait        <= '0;
    end else begin
      r_wait <= '0;
      case (r_state)
        S_IDLE: r_state <= S_FETCH;
        S_FETCH: begin
          if (bus.mem_ready) begin
            r_state <= S_DECODE;
          end else if (w_timeout) begin
            r_state <= S_ERROR;
            r_err   <= 2'b10;
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end
        S_DECODE: begin
          if (w_legal) begin
            r_state <= S_EXEC;
          end else begin
            r_state <= S_ERROR;
            r_err   <= 2'b01;
          end
        end
        S_EXEC: begin
          if (w_is_r || w_is_i) begin
            r_state <= S_WB;
          end else if (w_is_ld || w_is_sd) begin
            r_state <= S_MEM;
          end else if (w_is_beq) begin
            r_state       <= S_FETCH;
            r_instr_count <= r_instr_count + CNT_W'(1);
          end else begin
            r_state <= S_ERROR;
            r_err   <= 2'b01;
          end
        end
        S_MEM: begin
          if (bus.mem_ready) begin
            if (w_is_ld) begin
              r_state <= S_WB;
            end else begin
              r_state       <= S_FETCH;
              r_instr_count <= r_instr_count + CNT_W'(1);
            end
          end else if (w_timeout) begin
            r_state <= S_ERROR;
            r_err   <= 2'b10;
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end
        S_WB: begin
          r_state       <= S_FETCH;
          r_instr_count <= r_instr_count + CNT_W'(1);
        end
        S_ERROR: r_state <= S_ERROR;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  logic       w_mem_req, w_mem_we, w_i_or_d, w_ir_write, w_pc_write, w_pc_src;
  logic       w_alu_src_a, w_reg_write, w_mem_to_reg;
  logic [1:0] w_alu_src_b, w_alu_op;

  // Control decode from state and opcode; ir_write/pc_write follow
  // mem_ready in FETCH and zero in BEQ-EXEC within the same cycle.
  always_comb begin
    w_mem_req    = 1'b0;
    w_mem_we     = 1'b0;
    w_i_or_d     = 1'b0;
    w_ir_write   = 1'b0;
    w_pc_write   = 1'b0;
    w_pc_src     = 1'b0;
    w_alu_src_a  = 1'b0;
    w_alu_src_b  = 2'b00;
    w_alu_op     = 2'b00;
    w_reg_write  = 1'b0;
    w_mem_to_reg = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_req   = 1'b1;
        w_alu_src_b = 2'b01;
        w_ir_write  = bus.mem_ready;
        w_pc_write  = bus.mem_ready;
      end
      S_EXEC: begin
        w_alu_src_a = w_legal;
        if (w_is_r) begin
          w_alu_op = 2'b10;
        end else if (w_is_i) begin
          w_alu_src_b = 2'b10;
          w_alu_op    = 2'b10;
        end else if (w_is_ld || w_is_sd) begin
          w_alu_src_b = 2'b10;
        end else if (w_is_beq) begin
          w_alu_op   = 2'b01;
          w_pc_src   = 1'b1;
          w_pc_write = bus.zero;
        end
      end
      S_MEM: begin
        w_mem_req = 1'b1;
        w_i_or_d  = 1'b1;
        w_mem_we  = w_is_sd;
      end
      S_WB: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = w_is_ld;
      end
      default: ;
    endcase
  end

  assign bus.state       = r_state;
  assign bus.err         = r_err;
  assign bus.instr_count = r_instr_count;
  assign bus.mem_req     = w_mem_req;
  assign bus.mem_we      = w_mem_we;
  assign bus.i_or_d      = w_i_or_d;
  assign bus.ir_write    = w_ir_write;
  assign bus.pc_write    = w_pc_write;
  assign bus.pc_src      = w_pc_src;
  assign bus.alu_src_a   = w_alu_src_a;
  assign bus.alu_src_b   = w_alu_src_b;
  assign bus.alu_op      = w_alu_op;
  assign bus.reg_write   = w_reg_write;
  assign bus.mem_to_reg  = w_mem_to_reg;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: a per-instruction reference model
// expands each instruction into its expected cycle-by-cycle observation,
// the driver applies inputs and queues expectations, and a negedge monitor
// pops and compares. A second narrow-counter instance covers wraparound.
module tb_multicycle_ctrl;

  localparam int unsigned TIMEOUT = 16;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  typedef struct packed {
    logic [2:0]  state;
    logic        mem_req;
    logic        mem_we;
    logic        i_or_d;
    logic        ir_write;
    logic        pc_write;
    logic        pc_src;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  alu_op;
    logic        reg_write;
    logic        mem_to_reg;
    logic [1:0]  err;
    logic [31:0] cnt;
  } obs_t;

  typedef struct packed {
    logic       rdy;
    logic [6:0] op;
    logic       z;
    obs_t       exp;
  } cyc_t;

  logic clk    = 1'b0;
  logic reset  = 1'b0;
  logic reset2 = 1'b0;
  always #5 clk = ~clk;

  multicycle_ctrl_if #(.CNT_W(32)) bus ();
  multicycle_ctrl_if #(.CNT_W(4))  bus2 ();

  multicycle_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  multicycle_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(4)) dut2 (
    .clk(clk), .reset(reset2), .bus(bus2)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_cnt  = '0;
  cyc_t        plan[$];
  obs_t        sb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic obs_t sample();
    obs_t a;
    a.state = bus.state;         a.mem_req = bus.mem_req;     a.mem_we = bus.mem_we;
    a.i_or_d = bus.i_or_d;       a.ir_write = bus.ir_write;   a.pc_write = bus.pc_write;
    a.pc_src = bus.pc_src;       a.alu_src_a = bus.alu_src_a; a.alu_src_b = bus.alu_src_b;
    a.alu_op = bus.alu_op;       a.reg_write = bus.reg_write; a.mem_to_reg = bus.mem_to_reg;
    a.err = bus.err;             a.cnt = bus.instr_count;
    return a;
  endfunction

  // Monitor: compare every queued expectation mid-cycle
  always @(negedge clk) begin
    obs_t e, a;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      a = sample();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL cycle @%0t: state got %0d exp %0d, obs got %h exp %h",
                 $time, a.state, e.state, a, e);
      end
    end
  end

  function automatic obs_t base(input logic [2:0] st);
    obs_t o;
    o = '0;
    o.state = st;
    o.cnt   = m_cnt;
    return o;
  endfunction

  task automatic add(input logic rdy, input logic [6:0] op, input logic z, input obs_t e);
    cyc_t c;
    c.rdy = rdy; c.op = op; c.z = z; c.exp = e;
    plan.push_back(c);
  endtask

  // Reference model: one instruction as a list of phase cycles.
  // fw/mw = unanswered request cycles before mem_ready in FETCH/MEM.
  task automatic plan_instr(input logic [6:0] op, input logic z, input int fw, input int mw,
                            output bit errored, output logic [1:0] code);
    obs_t o;
    logic rdy;
    bit is_ld, is_sd, is_beq, legal;
    errored = 0; code = 2'b00;
    is_ld = (op == OP_LD); is_sd = (op == OP_SD); is_beq = (op == OP_BEQ);
    legal = (op == OP_R) || (op == OP_I) || is_ld || is_sd || is_beq;
    for (int k = 0; k <= fw && k < int'(TIMEOUT); k++) begin
      rdy = (k == fw);
      o = base(3'd1);
      o.mem_req = 1'b1; o.alu_src_b = 2'b01; o.ir_write = rdy; o.pc_write = rdy;
      add(rdy, 7'($urandom), z, o);
    end
    if (fw >= int'(TIMEOUT)) begin errored = 1; code = 2'b10; return; end
    add(1'b0, op, z, base(3'd2));
    if (!legal) begin errored = 1; code = 2'b01; return; end
    o = base(3'd3);
    o.alu_src_a = 1'b1;
    if (op == OP_R)       begin o.alu_op = 2'b10; end
    else if (op == OP_I)  begin o.alu_src_b = 2'b10; o.alu_op = 2'b10; end
    else if (is_beq)      begin o.alu_op = 2'b01; o.pc_src = 1'b1; o.pc_write = z; end
    else                  begin o.alu_src_b = 2'b10; end
    add(1'b0, op, z, o);
    if (is_beq) begin m_cnt++; return; end
    if (is_ld || is_sd) begin
      for (int k = 0; k <= mw && k < int'(TIMEOUT); k++) begin
        o = base(3'd4);
        o.mem_req = 1'b1; o.i_or_d = 1'b1; o.mem_we = is_sd;
        add(k == mw, op, z, o);
      end
      if (mw >= int'(TIMEOUT)) begin errored = 1; code = 2'b10; return; end
      if (is_sd) begin m_cnt++; return; end
    end
    o = base(3'd5);
    o.reg_write = 1'b1; o.mem_to_reg = is_ld;
    add(1'b0, op, z, o);
    m_cnt++;
  endtask

  task automatic plan_error(input logic [1:0] code, input int n);
    obs_t o;
    for (int k = 0; k < n; k++) begin
      o = base(3'd7);
      o.err = code;
      add(1'($urandom), 7'($urandom), 1'($urandom), o);
    end
  endtask

  task automatic drive_plan();
    cyc_t c;
    while (plan.size() > 0) begin
      @(posedge clk); #1;
      c = plan.pop_front();
      bus.mem_ready = c.rdy; bus.opcode = c.op; bus.zero = c.z;
      sb.push_back(c.exp);
    end
  endtask

  task automatic reset_release();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    bus.mem_ready = 1'b0;
    m_cnt = '0;
    sb.push_back(base(3'd0));
  endtask

  task automatic do_reset();
    @(negedge clk); #2;
    reset = 1'b0;
    reset_release();
  endtask

  task automatic run(input logic [6:0] op, input logic z, input int fw, input int mw);
    bit errored;
    logic [1:0] code;
    plan_instr(op, z, fw, mw, errored, code);
    if (errored) plan_error(code, 20);
    drive_plan();
    if (errored) do_reset();
  endtask

  initial begin
    logic [6:0] ops[5];
    logic [6:0] op;
    int fw, mw;
    ops[0] = OP_R; ops[1] = OP_I; ops[2] = OP_LD; ops[3] = OP_SD; ops[4] = OP_BEQ;
    bus.mem_ready = 1'b0; bus.opcode = '0; bus.zero = 1'b0;
    bus2.mem_ready = 1'b1; bus2.opcode = OP_R; bus2.zero = 1'b0;

    #12;
    check("reset_state", 64'(bus.state), 64'd0);
    check("reset_mem_req", 64'(bus.mem_req), 64'd0);
    check("reset_count", 64'(bus.instr_count), 64'd0);
    check("reset_err", 64'(bus.err), 64'd0);
    @(posedge clk); #1;
    reset_release();

    // Directed: back-to-back R, LD with wait states, BEQ taken/not taken
    repeat (3) run(OP_R, 1'b0, 0, 0);
    run(OP_LD, 1'b0, 0, 2);
    run(OP_BEQ, 1'b1, 0, 0);
    run(OP_BEQ, 1'b0, 0, 0);
    run(OP_I, 1'b0, 1, 0);
    run(OP_SD, 1'b1, 0, 3);
    // Illegal opcode, then FETCH/MEM timeout and last-cycle rescue
    run(7'b1111111, 1'b0, 0, 0);
    run(OP_R, 1'b0, 16, 0);
    run(OP_R, 1'b0, 15, 0);
    run(OP_LD, 1'b0, 0, 15);
    run(OP_SD, 1'b0, 0, 16);

    // Random instruction stream
    for (int n = 0; n < 60; n++) begin
      op = ops[$urandom_range(0, 4)];
      if ($urandom_range(0, 19) == 0) op = 7'($urandom);
      fw = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(0, 3));
      mw = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) fw = 16;
      if ($urandom_range(0, 29) == 0) mw = int'($urandom_range(15, 16));
      run(op, 1'($urandom), fw, mw);
    end

    // Reset during a waiting SD store
    run(OP_R, 1'b0, 0, 0);
    begin
      bit errored;
      logic [1:0] code;
      plan_instr(OP_SD, 1'b0, 0, 5, errored, code);
      while (plan.size() > 5) void'(plan.pop_back());
      drive_plan();
      @(negedge clk); #2;
      reset = 1'b0;
      #1;
      check("midrst_state", 64'(bus.state), 64'd0);
      check("midrst_mem_req", 64'(bus.mem_req), 64'd0);
      check("midrst_mem_we", 64'(bus.mem_we), 64'd0);
      check("midrst_count", 64'(bus.instr_count), 64'd0);
      reset_release();
    end
    run(OP_R, 1'b0, 0, 0);

    @(negedge clk); #1;
    check("sb_drained", 64'(sb.size()), 64'd0);

    // Counter wrap on a 4-bit instance: R-type, zero-wait, 4 cycles each
    @(posedge clk); #1;
    reset2 = 1'b1;
    for (int n = 1; n <= 69; n++) begin
      @(posedge clk); #1;
      if (n == 1)  check("wrap_first_fetch", 64'(bus2.state), 64'd1);
      if (n == 61 || n == 65 || n == 69)
        check("wrap_count", 64'(bus2.instr_count), 64'(((n - 1) / 4) % 16));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
